// File: rtl/serial_sum_accumulator_if.sv
// Operand stream in, result/status out for the serial sum accumulator.
// master drives go_l/inA; slave is the accumulator.
interface serial_sum_accumulator_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic          go_l;
  logic [W-1:0]  inA;
  logic          done;
  logic          busy;
  logic [W-1:0]  sum;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output go_l, inA,
    input  done, busy, sum, count, overflow
  );

  modport slave (
    input  go_l, inA,
    output done, busy, sum, count, overflow
  );
endinterface

// File: rtl/serial_sum_accumulator.sv
// Sums a zero-terminated operand stream after an active-low go strobe.
// Holds sum/count/overflow with a level done until the next start.
module serial_sum_accumulator #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input logic ck,
  input logic reset_l,
  serial_sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [W:0]    add;
  logic          start;
  logic          nz;

  assign start = !bus.go_l;
  assign nz    = |bus.inA;
  assign add   = {1'b0, sum_q} + {1'b0, bus.inA};

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // a start always discards the held result
        if (start) begin
          sum_d   = bus.inA;
          count_d = nz ? CW'(1) : '0;
          ovf_d   = 1'b0;
          state_d = nz ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (nz) begin
          sum_d = add[W-1:0];
          ovf_d = ovf_q | add[W];
          if (count_q != '1)
            count_d = count_q + CW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.done     = (state_q == S_DONE);
  assign bus.busy     = (state_q == S_ACCUM);
  assign bus.sum      = sum_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_sum_accumulator.sv
// Bench for serial_sum_accumulator: CW=8 and CW=2 instances share stimulus.
// A sequence-level model is checked every cycle, plus literal spot checks.
module tb_serial_sum_accumulator;

  logic       ck = 1'b0;
  logic       reset_l = 1'b0;
  logic       go_l = 1'b1;
  logic [7:0] inA = 8'h00;

  int total = 0;
  int bad = 0;

  serial_sum_accumulator_if #(.W(8), .CW(8)) bus0 ();
  serial_sum_accumulator_if #(.W(8), .CW(2)) bus1 ();

  assign bus0.go_l = go_l;
  assign bus0.inA  = inA;
  assign bus1.go_l = go_l;
  assign bus1.inA  = inA;

  serial_sum_accumulator #(.W(8), .CW(8)) dut0 (
    .ck(ck), .reset_l(reset_l), .bus(bus0)
  );
  serial_sum_accumulator #(.W(8), .CW(2)) dut1 (
    .ck(ck), .reset_l(reset_l), .bus(bus1)
  );

  always #5 ck = ~ck;

  // model: phase 0 idle, 1 running, 2 result held
  int m_ph [2];
  int m_sum[2];
  int m_cnt[2];
  int m_ovf[2];
  int cmax [2] = '{255, 3};

  always @(posedge ck or negedge reset_l) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_l) begin
        m_ph[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (m_ph[i] == 1) begin
        if (inA != 0) begin
          if (m_sum[i] + int'(inA) > 255) m_ovf[i] = 1;
          m_sum[i] = (m_sum[i] + int'(inA)) % 256;
          if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        end else begin
          m_ph[i] = 2;
        end
      end else if (!go_l) begin
        m_sum[i] = int'(inA);
        m_cnt[i] = (inA != 0) ? 1 : 0;
        m_ovf[i] = 0;
        m_ph[i]  = (inA != 0) ? 1 : 2;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge ck) begin
    chk("model0.done", int'(bus0.done), int'(m_ph[0] == 2));
    chk("model0.busy", int'(bus0.busy), int'(m_ph[0] == 1));
    chk("model0.sum", int'(bus0.sum), m_sum[0]);
    chk("model0.count", int'(bus0.count), m_cnt[0]);
    chk("model0.ovf", int'(bus0.overflow), m_ovf[0]);
    chk("model1.done", int'(bus1.done), int'(m_ph[1] == 2));
    chk("model1.busy", int'(bus1.busy), int'(m_ph[1] == 1));
    chk("model1.sum", int'(bus1.sum), m_sum[1]);
    chk("model1.count", int'(bus1.count), m_cnt[1]);
    chk("model1.ovf", int'(bus1.overflow), m_ovf[1]);
  end

  task automatic cyc(input logic g, input logic [7:0] a);
    go_l = g;
    inA  = a;
    @(posedge ck);
    #1;
  endtask

  task automatic res0(input string t, input int d, input int b,
                      input int s, input int c, input int o);
    chk({t, ".done"}, int'(bus0.done), d);
    chk({t, ".busy"}, int'(bus0.busy), b);
    chk({t, ".sum"}, int'(bus0.sum), s);
    chk({t, ".count"}, int'(bus0.count), c);
    chk({t, ".ovf"}, int'(bus0.overflow), o);
  endtask

  initial begin
    #12;
    reset_l = 1'b1;
    @(posedge ck); #1;
    res0("reset", 0, 0, 0, 0, 0);

    // test 1: async reset mid-ACCUM
    cyc(1'b0, 8'h05);
    cyc(1'b1, 8'h03);
    res0("t1_pre", 0, 1, 8, 2, 0);
    #3;
    reset_l = 1'b0;
    #1;
    res0("t1_async", 0, 0, 0, 0, 0);
    @(negedge ck); #1;
    reset_l = 1'b1;
    @(posedge ck); #1;
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h00);
    res0("t1_idle", 0, 0, 0, 0, 0);

    // test 2: basic sequence
    cyc(1'b0, 8'h05);
    res0("t2_e1", 0, 1, 5, 1, 0);
    cyc(1'b1, 8'h03);
    cyc(1'b1, 8'h07);
    cyc(1'b1, 8'h00);
    res0("t2_done", 1, 0, 15, 3, 0);
    cyc(1'b1, 8'h09);
    cyc(1'b1, 8'h00);
    res0("t2_hold", 1, 0, 15, 3, 0);

    // test 3: zero start operand
    cyc(1'b0, 8'h00);
    res0("t3", 1, 0, 0, 0, 0);

    // test 4: wrap with overflow, then restart from DONE
    cyc(1'b0, 8'hF0);
    cyc(1'b1, 8'h20);
    cyc(1'b1, 8'h00);
    res0("t4_wrap", 1, 0, 16, 2, 1);
    cyc(1'b0, 8'h01);
    res0("t4_restart", 0, 1, 1, 1, 0);
    cyc(1'b1, 8'h00);
    res0("t4_done", 1, 0, 1, 1, 0);

    // test 5: go_l ignored during ACCUM
    cyc(1'b0, 8'h02);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    res0("t5", 1, 0, 4, 3, 0);
    cyc(1'b1, 8'h00);

    // test 6: count saturation on the CW=2 instance
    cyc(1'b0, 8'h01);
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h00);
    chk("t6.cw2_count", int'(bus1.count), 3);
    chk("t6.cw2_sum", int'(bus1.sum), 7);
    chk("t6.cw2_ovf", int'(bus1.overflow), 0);
    chk("t6.cw2_done", int'(bus1.done), 1);
    res0("t6_cw8", 1, 0, 7, 7, 0);

    cyc(1'b1, 8'h00);
    @(negedge ck);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sum_accumulator.md
Name: serial_sum_accumulator

Overview:
Upstream producer stage for the downstream display/capture thread. Started by an active-low go strobe, it samples a stream of operands on inA, one per clock, and adds them. The stream ends at the first zero operand. On completion it presents a stable sum with a level done, which the downstream stage uses as its load qualifier. It also reports operand count and a sticky overflow flag for the testbench LEDs.

Parameters:
W, 8, width of operands and sum.
CW, 8, width of operand counter.

Ports:
ck  input  1  system clock, all state updates on rising edge.
reset_l  input  1  reset, asynchronous, active-low.
go_l  input  1  active-low start request; sampled on ck.
inA  input  W  operand stream; value 0 terminates a sequence.
done  output  1  high while a finished result is held.
busy  output  1  high while in ACCUM.
sum  output  W  running or final sum, modulo 2^W.
count  output  CW  number of nonzero operands summed; saturating.
overflow  output  1  sticky; set if any addition in the current sequence carried out of bit W-1.

Behaviour:
- Interface: one clock (ck); reset (reset_l) is asynchronous and active-low.
- Reset (reset_l=0, any time, including mid-sequence): state=IDLE, sum=0, count=0, overflow=0, done=0, busy=0. Effect is immediate, without waiting for ck.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- States:
  - IDLE: done=0, busy=0.
  - ACCUM: busy=1, done=0.
  - DONE: done=1, busy=0.
- Start (in IDLE or DONE, edge with go_l=0), which discards any previous result:
  - If inA!=0: next state ACCUM; sum<=inA, count<=1, overflow<=0.
  - If inA==0: next state DONE; sum<=0, count<=0, overflow<=0.
- IDLE or DONE with go_l=1: hold all registers. DONE holds done=1 and the result indefinitely.
- ACCUM, each edge:
  - If inA!=0: sum<=sum+inA (truncated to W bits). overflow<=overflow | carry-out. count<=count+1, saturating at 2^CW-1 (no wrap).
  - If inA==0: next state DONE; sum, count and overflow are held.
- go_l is ignored while in ACCUM. A restart is only possible from IDLE or DONE.
- Latency: with the go edge carrying a0 and N nonzero operands total, done rises after edge N+1, i.e. the edge that samples the terminating zero.
- On a restart from DONE, done falls after the start edge. Downstream sees done low for at least one cycle before the next result, unless the restart operand is 0, in which case done stays high with sum=0.
- Wrap-around: the sum wraps modulo 2^W and overflow is set. The count saturates rather than wrapping.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
1. Assert reset_l=0 mid-ACCUM, asynchronously between edges -> all outputs are 0 immediately. After release, stays in IDLE with done=0 while go_l=1.
2. go_l=0 for one edge with inA=0x05, then inA=0x03, 0x07, 0x00 on successive edges -> busy=1 after edge 1. done=1 after edge 4 with sum=0x0F, count=3, overflow=0. Outputs hold thereafter.
3. go_l=0 with inA=0x00 -> done=1 after 1 edge, sum=0x00, count=0, busy never asserts.
4. Start with inA=0xF0, then 0x20, then 0x00 -> sum=0x10, count=2, overflow=1. Restart from DONE with 0x01, 0x00 -> done falls for one cycle, then sum=0x01, count=1, overflow=0.
5. During ACCUM, toggle go_l low while feeding 0x01, 0x01, 0x00 after a start with 0x02 -> go_l has no effect; sum=0x04, count=3.
6. CW=2: feed seven 0x01 operands then 0x00 -> count saturates at 3, sum=0x07, overflow=0.
